left_normalizer49: RTL and testbench
====================================

Name: left_normalizer49

Overview:
- Post-add normalizer for the FP32 adder datapath. It is the counterpart of the alignment right-shifter.
- Takes the raw 49-bit mantissa sum (carry bit plus 48-bit aligned field) and the common exponent. Finds the leading one and shifts left (or right by 1 on carry-out) so the hidden bit lands at the top.
- Outputs a 24-bit normalized mantissa, an adjusted exponent, and zero/overflow/underflow flags.
- 2-stage pipeline that accepts one operand per cycle and feeds the rounding/pack stage.

Parameters:
- MANT_W, 24, normalized mantissa width including hidden bit
- EXP_W, 8, exponent width
- EXP_MAX, 255, reserved all-ones exponent (Inf)

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- valid_in  input  1  operand valid, sampled every cycle
- in_data  input  49  bit 48 = adder carry-out; bits 47:24 = mantissa field (hidden-bit position at 47); bits 23:0 = guard/shifted-out bits
- in_exp  input  8  biased exponent of the aligned operands
- valid_out  output  1  result valid, valid_in delayed 2 cycles
- out_mant  output  24  normalized mantissa, bit 23 = hidden bit
- out_exp  output  8  adjusted biased exponent
- out_zero  output  1  exact zero result
- out_ovf  output  1  exponent overflow, result forced to Inf
- out_unf  output  1  exponent underflow, result flushed to zero

Behaviour:
- Reset (rstn low, asynchronous): all pipeline registers and all outputs go to 0 immediately. Reset mid-flight discards in-flight operands; valid_out stays 0 until 2 cycles after the first valid_in following release.
- Valid chain: the valid flag for each stage is registered every cycle. valid_out equals valid_in delayed exactly 2 clocks, including bubbles. Back-to-back operands are accepted every cycle. There is no backpressure.
- Data/flag registers of a stage load only when that stage's incoming valid is 1; otherwise they hold their previous value.
- Stage 1 (leading-one detect), registered:
  - carry = in_data[48].
  - all_zero = (in_data == 0).
  - lz = number of leading zeros in in_data[47:0], range 0..47, a 6-bit count. Don't-care when all_zero or carry.
  - in_data[47:0] and in_exp are registered alongside.
- Stage 2 (shift and exponent adjust), registered outputs. Cases are evaluated in priority order:
  - all_zero: out_mant=0, out_exp=0, out_zero=1, ovf=0, unf=0.
  - carry=1: out_mant = in_data[48:25] (right shift by 1, truncate). out_exp = in_exp+1. If in_exp+1 >= EXP_MAX: out_exp=255, out_mant=0, out_ovf=1.
  - otherwise, when in_exp > lz: out_mant = (in_data[47:0] << lz)[47:24] and out_exp = in_exp - lz.
  - otherwise, when in_exp <= lz: underflow, flush to zero (no subnormals). out_mant=0, out_exp=0, out_unf=1, out_zero=0.
- In each case, any flag not named is 0.
- No rounding is performed; bits shifted below bit 24 are dropped. Rounding is done downstream.
- At most one of out_zero, out_ovf, out_unf is set.
- Exponent arithmetic uses 9 bits internally so in_exp+1 and in_exp-lz never wrap silently.

Test Plan:
- Reset/hold: rstn low with valid_in=1 -> all outputs 0. Release, single valid_in -> valid_out high exactly 2 cycles later, then outputs hold while valid_in=0.
- Already normal: in_data=49'h0_8000_0000_0000, in_exp=127 -> out_mant=24'h800000, out_exp=127, all flags 0.
- Carry-out: in_data=49'h1_8000_0000_0000, in_exp=127 -> out_mant=24'hC00000, out_exp=128. Same data with in_exp=254 -> out_exp=255, out_mant=0, out_ovf=1.
- Left shift by 10: in_data=49'h0_0020_0000_0000, in_exp=127 -> out_mant=24'h800000, out_exp=117. Same data with in_exp=10 -> out_unf=1, out_mant=0, out_exp=0.
- Zero and extreme shift: in_data=0, in_exp=100 -> out_zero=1, out_exp=0. in_data=49'h1 (lz=47), in_exp=200 -> out_mant=24'h800000, out_exp=153.
- Streaming: 4 consecutive valid operands from the cases above, then a bubble, then 1 more -> results appear in order on 4 consecutive cycles. The valid_out bubble lines up with the input bubble.

Source files
------------

// File: rtl/left_normalizer49_if.sv
// Operand/result bundle for the post-add left normalizer.
// The master drives operands; the slave (the normalizer) returns normalized results.
interface left_normalizer49_if #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
);
    logic                valid_in;
    logic [2*MANT_W:0]   in_data;
    logic [EXP_W-1:0]    in_exp;
    logic                valid_out;
    logic [MANT_W-1:0]   out_mant;
    logic [EXP_W-1:0]    out_exp;
    logic                out_zero;
    logic                out_ovf;
    logic                out_unf;

    modport master (
        output valid_in, in_data, in_exp,
        input  valid_out, out_mant, out_exp, out_zero, out_ovf, out_unf
    );

    modport slave (
        input  valid_in, in_data, in_exp,
        output valid_out, out_mant, out_exp, out_zero, out_ovf, out_unf
    );
endinterface

// File: rtl/left_normalizer49.sv
// Post-add normalizer: leading-one detect in stage 1, shift and exponent
// adjust in stage 2. One operand per cycle, no backpressure.
module left_normalizer49 #(
    parameter int MANT_W  = 24,
    parameter int EXP_W   = 8,
    parameter int EXP_MAX = 255
) (
    input  logic               clk,
    input  logic               rstn,
    left_normalizer49_if.slave bus
);
    localparam int FW  = 2 * MANT_W;
    localparam int LZW = $clog2(FW);

    logic [1:0]        vld_q;

    // Stage 1 state
    logic              s1_carry_q, s1_carry_d;
    logic              s1_zero_q,  s1_zero_d;
    logic [LZW-1:0]    s1_lz_q,    s1_lz_d;
    logic [FW-1:0]     s1_data_q;
    logic [EXP_W-1:0]  s1_exp_q;

    // Stage 2 (output) state
    logic [MANT_W-1:0] mant_q, mant_d;
    logic [EXP_W-1:0]  oexp_q, oexp_d;
    logic              zero_q, zero_d;
    logic              ovf_q,  ovf_d;
    logic              unf_q,  unf_d;

    logic [EXP_W:0]    exp_inc, exp_sub, lz_ext;
    logic [FW-1:0]     shifted;
    logic              found;

    // Leading-zero count over the aligned field; value is irrelevant when the
    // field is all zero or the carry is set.
    always_comb begin
        s1_carry_d = bus.in_data[FW];
        s1_zero_d  = (bus.in_data == '0);
        s1_lz_d    = '0;
        found      = 1'b0;
        for (int i = FW - 1; i >= 0; i--) begin
            if (!found) begin
                if (bus.in_data[i]) found = 1'b1;
                else                s1_lz_d = s1_lz_d + 1'b1;
            end
        end
    end

    // 9-bit exponent math so +1 and -lz cannot wrap before the range checks.
    assign lz_ext  = {{(EXP_W + 1 - LZW){1'b0}}, s1_lz_q};
    assign exp_inc = {1'b0, s1_exp_q} + 1'b1;
    assign exp_sub = {1'b0, s1_exp_q} - lz_ext;
    assign shifted = s1_data_q << s1_lz_q;

    always_comb begin
        mant_d = '0;
        oexp_d = '0;
        zero_d = 1'b0;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        if (s1_zero_q) begin
            zero_d = 1'b1;
        end else if (s1_carry_q) begin
            if (exp_inc >= (EXP_W + 1)'(EXP_MAX)) begin
                ovf_d  = 1'b1;
                oexp_d = EXP_W'(EXP_MAX);
            end else begin
                mant_d = {s1_carry_q, s1_data_q[FW-1:MANT_W+1]};
                oexp_d = exp_inc[EXP_W-1:0];
            end
        end else if ({1'b0, s1_exp_q} > lz_ext) begin
            mant_d = shifted[FW-1:MANT_W];
            oexp_d = exp_sub[EXP_W-1:0];
        end else begin
            unf_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q      <= '0;
            s1_carry_q <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_lz_q    <= '0;
            s1_data_q  <= '0;
            s1_exp_q   <= '0;
            mant_q     <= '0;
            oexp_q     <= '0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            vld_q <= {vld_q[0], bus.valid_in};
            if (bus.valid_in) begin
                s1_carry_q <= s1_carry_d;
                s1_zero_q  <= s1_zero_d;
                s1_lz_q    <= s1_lz_d;
                s1_data_q  <= bus.in_data[FW-1:0];
                s1_exp_q   <= bus.in_exp;
            end
            if (vld_q[0]) begin
                mant_q <= mant_d;
                oexp_q <= oexp_d;
                zero_q <= zero_d;
                ovf_q  <= ovf_d;
                unf_q  <= unf_d;
            end
        end
    end

    assign bus.valid_out = vld_q[1];
    assign bus.out_mant  = mant_q;
    assign bus.out_exp   = oexp_q;
    assign bus.out_zero  = zero_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_unf   = unf_q;
endmodule

// File: tb/tb_left_normalizer49.sv
// Bench for left_normalizer49: directed table, streaming/reset sequences and
// random operands against an arithmetic reference model.
module tb_left_normalizer49;
    typedef struct packed {
        logic [23:0] mant;
        logic [7:0]  exp;
        logic        z;
        logic        o;
        logic        u;
    } res_t;

    typedef struct {
        logic [48:0] d;
        logic [7:0]  e;
        res_t        r;
    } vec_t;

    typedef struct packed {
        logic v;
        res_t r;
    } slot_t;

    logic clk, rstn;
    int   errors = 0;
    int   checks = 0;
    slot_t pipe[$];
    res_t  held;
    logic  exp_v;
    vec_t  tbl[9];

    left_normalizer49_if #(.MANT_W(24), .EXP_W(8)) bus ();

    left_normalizer49 #(.MANT_W(24), .EXP_W(8), .EXP_MAX(255)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: locate the most significant one and apply the rules with
    // plain integer exponent arithmetic.
    function automatic res_t ref_model(logic [48:0] d, logic [7:0] e);
        res_t r;
        int p, lz, ne;
        logic [47:0] f;
        r = '0;
        if (d == 49'd0) begin
            r.z = 1'b1;
        end else if (d[48]) begin
            if (int'(e) + 1 >= 255) begin
                r.o = 1'b1;
                r.exp = 8'd255;
            end else begin
                r.mant = d[48:25];
                r.exp = 8'(int'(e) + 1);
            end
        end else begin
            p = 0;
            for (int i = 0; i < 48; i++) if (d[i]) p = i;
            lz = 47 - p;
            ne = int'(e) - lz;
            if (ne <= 0) r.u = 1'b1;
            else begin
                f = d[47:0] << lz;
                r.mant = f[47:24];
                r.exp = 8'(ne);
            end
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic ev, input res_t er);
        checks++;
        if (bus.valid_out !== ev || bus.out_mant !== er.mant || bus.out_exp !== er.exp ||
            bus.out_zero !== er.z || bus.out_ovf !== er.o || bus.out_unf !== er.u) begin
            errors++;
            $display("FAIL %s t=%0t: got v=%b mant=%h exp=%0d z=%b o=%b u=%b, want v=%b mant=%h exp=%0d z=%b o=%b u=%b",
                     nm, $time, bus.valid_out, bus.out_mant, bus.out_exp, bus.out_zero, bus.out_ovf,
                     bus.out_unf, ev, er.mant, er.exp, er.z, er.o, er.u);
        end
    endtask

    // One clock: drive inputs, advance, compare against the model pipeline.
    task automatic cycle(input logic v, input logic [48:0] d, input logic [7:0] e);
        slot_t s;
        bus.valid_in = v;
        bus.in_data  = d;
        bus.in_exp   = e;
        s.v = v;
        s.r = ref_model(d, e);
        pipe.push_back(s);
        @(posedge clk); #1;
        exp_v = 1'b0;
        if (pipe.size() == 2) begin
            s = pipe.pop_front();
            exp_v = s.v;
            if (s.v) held = s.r;
        end
        chk("model", exp_v, held);
    endtask

    task automatic assert_reset(input string nm);
        rstn = 1'b0;
        #1;
        pipe.delete();
        held = '0;
        chk(nm, 1'b0, held);
    endtask

    initial begin : main
        logic [7:0]  vout_bits;
        logic [63:0] r64;
        logic [48:0] d;
        logic        v;

        tbl[0] = '{49'h0_8000_0000_0000, 8'd127, '{24'h800000, 8'd127, 1'b0, 1'b0, 1'b0}};
        tbl[1] = '{49'h1_8000_0000_0000, 8'd127, '{24'hC00000, 8'd128, 1'b0, 1'b0, 1'b0}};
        tbl[2] = '{49'h0_0020_0000_0000, 8'd127, '{24'h800000, 8'd117, 1'b0, 1'b0, 1'b0}};
        tbl[3] = '{49'h0_0000_0000_0001, 8'd200, '{24'h800000, 8'd153, 1'b0, 1'b0, 1'b0}};
        tbl[4] = '{49'h0_0000_0000_0000, 8'd100, '{24'h000000, 8'd0,   1'b1, 1'b0, 1'b0}};
        tbl[5] = '{49'h1_8000_0000_0000, 8'd254, '{24'h000000, 8'd255, 1'b0, 1'b1, 1'b0}};
        tbl[6] = '{49'h0_0020_0000_0000, 8'd10,  '{24'h000000, 8'd0,   1'b0, 1'b0, 1'b1}};
        tbl[7] = '{49'h0_0020_0000_0000, 8'd11,  '{24'h800000, 8'd1,   1'b0, 1'b0, 1'b0}};
        tbl[8] = '{49'h1_0000_0000_0001, 8'd253, '{24'h800000, 8'd254, 1'b0, 1'b0, 1'b0}};

        held = '0;
        bus.valid_in = 1'b1;
        bus.in_data  = 49'h1_FFFF_FFFF_FFFF;
        bus.in_exp   = 8'd200;
        assert_reset("reset_out");
        repeat (3) begin
            @(posedge clk); #1;
            chk("reset_hold", 1'b0, held);
        end
        rstn = 1'b1;

        // Single operand: valid_out exactly two cycles later, then holds.
        cycle(1'b0, '0, '0);
        cycle(1'b1, tbl[0].d, tbl[0].e);
        cycle(1'b0, '0, '0);
        chk("single_lat", 1'b1, tbl[0].r);
        repeat (3) cycle(1'b0, 49'h1_2345_6789_ABCD, 8'd77);
        chk("single_hold", 1'b0, tbl[0].r);

        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, tbl[i].d, tbl[i].e);
            cycle(1'b0, '0, '0);
            chk($sformatf("tbl%0d", i), 1'b1, tbl[i].r);
            cycle(1'b0, '0, '0);
            chk($sformatf("tbl%0d_hold", i), 1'b0, tbl[i].r);
        end

        // Streaming with one bubble; the output bubble must line up.
        cycle(1'b0, '0, '0);
        for (int k = 0; k < 8; k++) begin
            if (k < 4)       cycle(1'b1, tbl[k].d, tbl[k].e);
            else if (k == 5) cycle(1'b1, tbl[4].d, tbl[4].e);
            else             cycle(1'b0, '0, '0);
            vout_bits[k] = bus.valid_out;
            if (k >= 1 && k <= 4) chk($sformatf("stream%0d", k - 1), 1'b1, tbl[k-1].r);
        end
        checks++;
        if (vout_bits !== 8'b0101_1110) begin
            errors++;
            $display("FAIL stream_valid: got %b want %b", vout_bits, 8'b0101_1110);
        end
        chk("stream_last", 1'b0, tbl[4].r);

        // Reset with operands in flight discards them.
        cycle(1'b1, tbl[1].d, tbl[1].e);
        bus.valid_in = 1'b1;
        bus.in_data  = tbl[2].d;
        bus.in_exp   = tbl[2].e;
        assert_reset("midflight_reset");
        @(posedge clk); #1;
        chk("midflight_hold", 1'b0, held);
        rstn = 1'b1;
        cycle(1'b0, '0, '0);
        cycle(1'b0, '0, '0);
        chk("after_reset", 1'b0, '0);

        for (int n = 0; n < 400; n++) begin
            v   = ($urandom_range(0, 3) != 0);
            r64 = {$urandom, $urandom} >> $urandom_range(0, 62);
            d   = r64[48:0];
            if ($urandom_range(0, 15) == 0) d = '0;
            cycle(v, d, 8'($urandom_range(0, 255)));
        end
        cycle(1'b0, '0, '0);
        cycle(1'b0, '0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
